wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ write-back requesters: ALU, load unit, multiply/divide unit.
- Round-robin arbitration with a per-requester valid/ready handshake.
- Output is registered, so the register-file write happens one cycle after the grant.
- Drives the register file's write_enable/next-style inputs; sits at the end of the write-back stage.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WIDTH, 32, data width.
- ADDR_BITS, 5, register index width.
- IDX_BITS, $clog2(NUM_REQ), requester index width (derived; do not override).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- stall  input  1  when 1, no grants are issued this cycle.
- req_valid  input  NUM_REQ  bit i set = requester i has a pending write.
- req_addr  input  NUM_REQ*ADDR_BITS  packed destination index; slice i belongs to requester i.
- req_data  input  NUM_REQ*WIDTH  packed write data; slice i belongs to requester i.
- req_ready  output  NUM_REQ  one-hot grant (combinational); all zeros when nothing is granted.
- rf_write_enable  output  1  registered write strobe to the register file.
- rf_addr  output  ADDR_BITS  registered destination index.
- rf_data  output  WIDTH  registered write data.
- grant_id  output  IDX_BITS  registered index of the last granted requester.

Behaviour:
- Reset (reset=0, async):
  - rf_write_enable=0, rf_addr=0, rf_data=0, grant_id=0.
  - Round-robin pointer ptr=0.
  - req_ready forced to all zeros while reset is low.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester holds valid, addr and data stable until it sees ready.
  - ready never depends on the granted requester's data.
- Arbitration, each cycle when stall=0:
  - Scan requesters starting at ptr, wrapping modulo NUM_REQ.
  - The first requester with valid=1 is granted; at most one ready bit is high.
  - On a grant to k: ptr <= (k+1) mod NUM_REQ; grant_id <= k.
  - No valid requester: no grant, ptr unchanged, rf_write_enable <= 0.
- Latency:
  - A request granted in cycle N gives rf_write_enable=1 with its addr/data in cycle N+1.
  - Back-to-back grants give one write per cycle.
- x0 suppression:
  - A grant with addr==0 is accepted normally (ready=1, ptr advances, grant_id updates).
  - rf_write_enable <= 0 for that cycle; rf_addr/rf_data still load the request.
- stall=1:
  - req_ready=0 and rf_write_enable <= 0.
  - ptr, grant_id, rf_addr and rf_data hold.
  - Requests stay pending.
- Output registers:
  - rf_addr and rf_data load only on a grant.
  - Otherwise they hold their previous values; only rf_write_enable deasserts.
- Single requester valid: it is granted every cycle regardless of ptr.
- Reset asserted mid-stream: any pending or in-flight write is dropped (rf_write_enable=0 immediately). No grant is issued until reset deasserts; the first cycle after release scans from requester 0.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of asserting valid, excluding stalled cycles.

Optional Feature:
- Macro: WB_ARB_CONFLICT_CNT_EN.
- Defined:
  - Adds output conflict_count (32 bits), reset to 0.
  - Increments by 1 each non-stalled cycle in which two or more req_valid bits are set.
  - Saturates at 32'hFFFF_FFFF.
  - Holds during stall.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release, then req_valid=3'b111 (addr 1/2/3, data A/B/C) held for 3 cycles -> grants 0,1,2 in cycles 1..3; rf_write_enable=1 cycles 2..4 with (1,A),(2,B),(3,C); grant_id 0,1,2.
- Only requester 2 valid for 4 cycles, addr=5, data=32'hDEAD_BEEF -> req_ready=3'b100 every cycle; four consecutive writes to 5 of 32'hDEAD_BEEF.
- Requester 1 valid with addr=0, data=32'h1234 -> req_ready[1]=1, ptr advances to 2, rf_write_enable stays 0, rf_data=32'h1234.
- All valid, stall=1 for 2 cycles, then 0 -> no ready and no write during the stall; the grant resumes at the held ptr value.
- Grant issued, then reset pulled low before the next edge -> rf_write_enable=0 immediately; after release, req_valid=3'b110 grants requester 1 first.
- With WB_ARB_CONFLICT_CNT_EN: 5 cycles of req_valid=3'b011, 1 of them stalled -> conflict_count=4; without the macro, elaborates with no conflict_count port.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the shared register-file write port, with a registered write stage.
// Optional WB_ARB_CONFLICT_CNT_EN adds a saturating count of cycles in which requesters collide.
module wb_port_arbiter #(
    parameter  int NUM_REQ   = 3,
    parameter  int WIDTH     = 32,
    parameter  int ADDR_BITS = 5,
    localparam int IDX_BITS  = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]       req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rf_write_enable,
    output logic [ADDR_BITS-1:0]           rf_addr,
    output logic [WIDTH-1:0]               rf_data,
`ifdef WB_ARB_CONFLICT_CNT_EN
    output logic [31:0]                    conflict_count,
`endif
    output logic [IDX_BITS-1:0]            grant_id
);

    logic [NUM_REQ-1:0][ADDR_BITS-1:0] addr_arr;
    logic [NUM_REQ-1:0][WIDTH-1:0]     data_arr;
    logic [IDX_BITS-1:0]               ptr;
    logic [IDX_BITS-1:0]               sel;
    logic [IDX_BITS-1:0]               cand;
    logic [IDX_BITS-1:0]               ptr_next;
    logic                              found;
    logic                              grant;

    assign addr_arr = req_addr;
    assign data_arr = req_data;

    // Scan from ptr with wraparound; only valid bits feed the decision, never data.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDX_BITS'((int'(ptr) + off) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign grant     = found && !stall;
    assign ptr_next  = (sel == IDX_BITS'(NUM_REQ - 1)) ? '0 : sel + IDX_BITS'(1);
    assign req_ready = (grant && reset) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr             <= '0;
            grant_id        <= '0;
            rf_write_enable <= 1'b0;
            rf_addr         <= '0;
            rf_data         <= '0;
        end else if (grant) begin
            ptr             <= ptr_next;
            grant_id        <= sel;
            rf_addr         <= addr_arr[sel];
            rf_data         <= data_arr[sel];
            // Writes to x0 are consumed but never reach the register file.
            rf_write_enable <= (addr_arr[sel] != '0);
        end else begin
            rf_write_enable <= 1'b0;
        end
    end

`ifdef WB_ARB_CONFLICT_CNT_EN
    logic multi;
    assign multi = |(req_valid & (req_valid - NUM_REQ'(1)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            conflict_count <= '0;
        else if (!stall && multi && (conflict_count != 32'hFFFF_FFFF))
            conflict_count <= conflict_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a reference round-robin model predicts each
// grant and the registered write it should produce one cycle later.
module tb_wb_port_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int WIDTH     = 32;
    localparam int ADDR_BITS = 5;
    localparam int IDX_BITS  = 2;

    logic                         clock = 1'b0;
    logic                         reset = 1'b0;
    logic                         stall = 1'b0;
    logic [NUM_REQ-1:0]           req_valid = '0;
    logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]     req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         rf_write_enable;
    logic [ADDR_BITS-1:0]         rf_addr;
    logic [WIDTH-1:0]             rf_data;
    logic [IDX_BITS-1:0]          grant_id;
`ifdef WB_ARB_CONFLICT_CNT_EN
    logic [31:0]                  conflict_count;
`endif

    logic [ADDR_BITS-1:0] a [NUM_REQ];
    logic [WIDTH-1:0]     d [NUM_REQ];
    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    wb_port_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .rf_write_enable (rf_write_enable),
        .rf_addr         (rf_addr),
        .rf_data         (rf_data),
`ifdef WB_ARB_CONFLICT_CNT_EN
        .conflict_count  (conflict_count),
`endif
        .grant_id        (grant_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  gid;
        logic [31:0] cc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int          m_ptr;
    logic [1:0]  m_gid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_cc;
    int          last_k;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_gid = '0; m_addr = '0; m_data = '0; m_cc = '0;
        exp_q.delete();
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        exp_t e;
        int k;
        logic [2:0] rdy_exp;
        #1;
        k = -1;
        if (!stall)
            for (int off = 0; off < NUM_REQ; off++)
                if (k < 0 && req_valid[(m_ptr + off) % NUM_REQ]) k = (m_ptr + off) % NUM_REQ;
        rdy_exp = (k >= 0) ? 3'(1 << k) : 3'b000;
        chk("ready", 64'(req_ready), 64'(rdy_exp));
        e.we = 1'b0;
        if (k >= 0) begin
            m_gid  = 2'(k);
            m_addr = a[k];
            m_data = d[k];
            m_ptr  = (k + 1) % NUM_REQ;
            e.we   = (a[k] != 5'd0);
        end
        if (!stall && $countones(req_valid) >= 2 && m_cc != 32'hFFFF_FFFF) m_cc++;
        e.addr = m_addr; e.data = m_data; e.gid = m_gid; e.cc = m_cc;
        exp_q.push_back(e);
        last_k = k;
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        chk("rf_we",    64'(rf_write_enable), 64'(e.we));
        chk("rf_addr",  64'(rf_addr),         64'(e.addr));
        chk("rf_data",  64'(rf_data),         64'(e.data));
        chk("grant_id", 64'(grant_id),        64'(e.gid));
`ifdef WB_ARB_CONFLICT_CNT_EN
        chk("conflict", 64'(conflict_count),  64'(e.cc));
`endif
        @(negedge clock);
    endtask

    task automatic set_req(input int i, input logic [4:0] addr, input logic [31:0] data);
        a[i] = addr;
        d[i] = data;
    endtask

    initial begin
        logic [31:0] cc0;
        logic [2:0]  pend;
        for (int i = 0; i < NUM_REQ; i++) begin a[i] = '0; d[i] = '0; end
        model_reset();

        // Reset state, with requests asserted to show ready is held low
        req_valid = 3'b111;
        @(negedge clock); @(negedge clock);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_we",    64'(rf_write_enable), 64'd0);
        chk("rst_addr",  64'(rf_addr), 64'd0);
        chk("rst_data",  64'(rf_data), 64'd0);
        chk("rst_gid",   64'(grant_id), 64'd0);
        reset = 1'b1;

        // All three valid: grants 0,1,2 in order
        set_req(0, 5'd1, 32'hAAAA_0001);
        set_req(1, 5'd2, 32'hBBBB_0002);
        set_req(2, 5'd3, 32'hCCCC_0003);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("rr_order", 64'(last_k), 64'(c));
            req_valid[c] = 1'b0;
        end

        // Single requester 2, granted every cycle
        req_valid = 3'b100;
        set_req(2, 5'd5, 32'hDEAD_BEEF);
        for (int c = 0; c < 4; c++) cycle();

        // Write to x0: consumed, not written
        req_valid = 3'b010;
        set_req(1, 5'd0, 32'h0000_1234);
        cycle();
        chk("x0_ptr", 64'(m_ptr), 64'd2);

        // Stall with all valid, then resume at held pointer (requester 2)
        req_valid = 3'b111;
        set_req(0, 5'd7, 32'h7777_0000);
        set_req(1, 5'd8, 32'h8888_0000);
        set_req(2, 5'd9, 32'h9999_0000);
        stall = 1'b1;
        cycle(); cycle();
        stall = 1'b0;
        cycle();
        chk("stall_resume", 64'(last_k), 64'd2);
        req_valid = 3'b000;

        // Grant seen, then reset asserted before the capturing edge
        req_valid = 3'b001;
        cycle();
        req_valid = 3'b010;
        #1;
        chk("pre_rst_ready", 64'(req_ready), 64'b010);
        reset = 1'b0;
        #1;
        chk("midrst_we",    64'(rf_write_enable), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        @(posedge clock); #1;
        chk("midrst_hold_we", 64'(rf_write_enable), 64'd0);
        @(negedge clock);
        model_reset();
        reset = 1'b1;
        req_valid = 3'b110;
        set_req(1, 5'd11, 32'h1111_0011);
        set_req(2, 5'd12, 32'h2222_0012);
        cycle();
        chk("post_rst_first", 64'(last_k), 64'd1);
        req_valid = 3'b000;
        cycle();

        // Five cycles of two requesters, one stalled: four conflicts
        cc0 = m_cc;
        req_valid = 3'b011;
        for (int c = 0; c < 5; c++) begin
            stall = (c == 2);
            cycle();
        end
        stall = 1'b0;
        chk("conflict_delta", 64'(m_cc - cc0), 64'd4);
        req_valid = 3'b000;

        // Random traffic that holds each request until it is granted
        pend = '0;
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1;
                    set_req(i, 5'($urandom_range(0, 31)), $urandom);
                end
            req_valid = pend;
            stall = ($urandom_range(0, 4) == 0);
            cycle();
            if (last_k >= 0) pend[last_k] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", checks, 0);
        $fatal(1);
    end

endmodule
